// File: rtl/ftdi_tx_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ftdi_tx_arbiter
// Description : Two-channel round-robin scheduler that feeds the transmit
//               byte stream of an FTDI async FIFO interface.
//               Each granted packet goes out as one framed burst:
//                 header {HDR_TAG, 3'b000, channel}, length (len-1), payload.
//               The host demultiplexes the logical channels using the header.
// Ports       :
//   clk_i            - clock
//   rst_i            - asynchronous active-high reset
//   chN_valid_i      - channel N has a payload byte / packet pending
//   chN_data_i[7:0]  - channel N payload byte
//   chN_len_i[7:0]   - channel N payload length minus 1 (sampled at grant)
//   chN_accept_o     - channel N payload byte consumed this cycle
//   outport_valid_o  - byte available to the FTDI transmitter
//   outport_data_o   - byte to the FTDI transmitter
//   outport_accept_i - FTDI transmitter takes the byte (valid & accept)
//   grant_o[1:0]     - one-hot current owner, 0 when idle
//   busy_o           - a frame is in progress
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module ftdi_tx_arbiter #(
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic       clk_i,
    input  logic       rst_i,

    input  logic       ch0_valid_i,
    input  logic [7:0] ch0_data_i,
    input  logic [7:0] ch0_len_i,
    output logic       ch0_accept_o,

    input  logic       ch1_valid_i,
    input  logic [7:0] ch1_data_i,
    input  logic [7:0] ch1_len_i,
    output logic       ch1_accept_o,

    output logic       outport_valid_o,
    output logic [7:0] outport_data_o,
    input  logic       outport_accept_i,

    output logic [1:0] grant_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_LEN  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       sel_q,   sel_d;     // owning channel of the current frame
    logic       last_q,  last_d;    // channel granted most recently
    logic [7:0] len_q,   len_d;     // payload length minus 1, latched at grant
    logic [7:0] cnt_q,   cnt_d;     // payload bytes still to send, minus 1

    logic       own_valid;
    logic [7:0] own_data;
    logic       pick;

    assign own_valid = sel_q ? ch1_valid_i : ch0_valid_i;
    assign own_data  = sel_q ? ch1_data_i  : ch0_data_i;

    // On a tie the channel that was not served last wins; otherwise the
    // single requester wins.
    assign pick = (ch0_valid_i && ch1_valid_i) ? ~last_q : ch1_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;            // channel 0 wins the first tie
            len_q   <= 8'h00;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        last_d          = last_q;
        len_d           = len_q;
        cnt_d           = cnt_q;
        outport_valid_o = 1'b0;
        outport_data_o  = 8'h00;
        ch0_accept_o    = 1'b0;
        ch1_accept_o    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ch0_valid_i || ch1_valid_i) begin
                    sel_d   = pick;
                    last_d  = pick;
                    len_d   = pick ? ch1_len_i : ch0_len_i;
                    state_d = ST_HDR;
                end
            end

            ST_HDR: begin
                outport_valid_o = 1'b1;
                outport_data_o  = {HDR_TAG, 3'b000, sel_q};
                if (outport_accept_i) begin
                    cnt_d   = len_q;
                    state_d = ST_LEN;
                end
            end

            ST_LEN: begin
                outport_valid_o = 1'b1;
                outport_data_o  = len_q;
                if (outport_accept_i) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                // Payload is a zero-latency pass-through from the owner.
                outport_valid_o = own_valid;
                outport_data_o  = own_data;
                ch0_accept_o    = ~sel_q & outport_accept_i;
                ch1_accept_o    =  sel_q & outport_accept_i;
                if (own_valid && outport_accept_i) begin
                    if (cnt_q == 8'h00) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign grant_o = busy_o ? (sel_q ? 2'b10 : 2'b01) : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_ftdi_tx_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_ftdi_tx_arbiter
// Description : Directed self-checking bench for ftdi_tx_arbiter.
//               Inputs change 1 time unit after the rising edge, outputs are
//               checked 1 time unit later, well before the next rising edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ftdi_tx_arbiter;

    logic       clk;
    logic       rst;
    logic       ch0_valid, ch1_valid;
    logic [7:0] ch0_data,  ch1_data;
    logic [7:0] ch0_len,   ch1_len;
    logic       ch0_accept, ch1_accept;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_accept;
    logic [1:0] grant;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    ftdi_tx_arbiter #(.HDR_TAG(4'hA)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ch0_valid_i      (ch0_valid),
        .ch0_data_i       (ch0_data),
        .ch0_len_i        (ch0_len),
        .ch0_accept_o     (ch0_accept),
        .ch1_valid_i      (ch1_valid),
        .ch1_data_i       (ch1_data),
        .ch1_len_i        (ch1_len),
        .ch1_accept_o     (ch1_accept),
        .outport_valid_o  (out_valid),
        .outport_data_o   (out_data),
        .outport_accept_i (out_accept),
        .grant_o          (grant),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic [1:0] g, input logic a0, input logic a1,
                           input logic b);
        chk({tag, ".valid"},  {7'd0, out_valid},  {7'd0, v});
        chk({tag, ".data"},   out_data,           d);
        chk({tag, ".grant"},  {6'd0, grant},      {6'd0, g});
        chk({tag, ".accept0"},{7'd0, ch0_accept}, {7'd0, a0});
        chk({tag, ".accept1"},{7'd0, ch1_accept}, {7'd0, a1});
        chk({tag, ".busy"},   {7'd0, busy},       {7'd0, b});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        ch0_valid  = 1'b0; ch0_data = 8'h00; ch0_len = 8'h00;
        ch1_valid  = 1'b0; ch1_data = 8'h00; ch1_len = 8'h00;
        out_accept = 1'b0;

        // Reset state
        #2;
        chk_out("reset", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;

        // Single packet on channel 0: A0 02 11 22 33
        ch0_valid = 1'b1; ch0_len = 8'h02; ch0_data = 8'h11; out_accept = 1'b1;
        #1 chk_out("single.idle", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(); chk_out("single.hdr", 1'b1, 8'hA0, 2'b01, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("single.len", 1'b1, 8'h02, 2'b01, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("single.d0",  1'b1, 8'h11, 2'b01, 1'b1, 1'b0, 1'b1);
        tick(); ch0_data = 8'h22;
        #1 chk_out("single.d1",  1'b1, 8'h22, 2'b01, 1'b1, 1'b0, 1'b1);
        tick(); ch0_data = 8'h33;
        #1 chk_out("single.d2",  1'b1, 8'h33, 2'b01, 1'b1, 1'b0, 1'b1);
        tick(); ch0_valid = 1'b0;
        #1 chk_out("single.end", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Tie and round robin after a fresh reset: ch0 first, then ch1
        rst = 1'b1;
        #1 chk_out("rst2", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        ch0_valid = 1'b1; ch0_len = 8'h00; ch0_data = 8'hC0;
        ch1_valid = 1'b1; ch1_len = 8'h00; ch1_data = 8'hD1;
        #1 chk_out("rr.idle0", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(); chk_out("rr.hdr0",  1'b1, 8'hA0, 2'b01, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("rr.len0",  1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("rr.dat0",  1'b1, 8'hC0, 2'b01, 1'b1, 1'b0, 1'b1);
        tick(); chk_out("rr.idle1", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(); chk_out("rr.hdr1",  1'b1, 8'hA1, 2'b10, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("rr.len1",  1'b1, 8'h00, 2'b10, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("rr.dat1",  1'b1, 8'hD1, 2'b10, 1'b0, 1'b1, 1'b1);
        tick(); chk_out("rr.idle2", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(); chk_out("rr.hdr2",  1'b1, 8'hA0, 2'b01, 1'b0, 1'b0, 1'b1);

        // Sink backpressure: header then length held for 5 cycles each
        out_accept = 1'b0; ch1_valid = 1'b0;
        #1 chk_out("bp.hdr", 1'b1, 8'hA0, 2'b01, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(); chk_out("bp.hdr", 1'b1, 8'hA0, 2'b01, 1'b0, 1'b0, 1'b1);
        end
        out_accept = 1'b1;
        #1 chk_out("bp.hdr_acc", 1'b1, 8'hA0, 2'b01, 1'b0, 1'b0, 1'b1);
        tick();
        out_accept = 1'b0; ch0_len = 8'h55;   // late length change is ignored
        #1 chk_out("bp.len", 1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(); chk_out("bp.len", 1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1);
        end
        out_accept = 1'b1;
        #1 chk_out("bp.len_acc", 1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1);
        tick();
        out_accept = 1'b0;
        #1 chk_out("bp.dat_noacc", 1'b1, 8'hC0, 2'b01, 1'b0, 1'b0, 1'b1);
        out_accept = 1'b1;
        #1 chk_out("bp.dat_acc",   1'b1, 8'hC0, 2'b01, 1'b1, 1'b0, 1'b1);
        tick(); ch0_valid = 1'b0;
        #1 chk_out("bp.end", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Source stall: ch1 len=3 (wins tie, ch0 was last), gap after byte 2
        ch1_valid = 1'b1; ch1_len = 8'h03; ch1_data = 8'h40;
        ch0_valid = 1'b1; ch0_len = 8'h00; ch0_data = 8'h50;
        #1 chk_out("stall.idle", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(); chk_out("stall.hdr", 1'b1, 8'hA1, 2'b10, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("stall.len", 1'b1, 8'h03, 2'b10, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("stall.d0",  1'b1, 8'h40, 2'b10, 1'b0, 1'b1, 1'b1);
        tick(); ch1_data = 8'h41;
        #1 chk_out("stall.d1",  1'b1, 8'h41, 2'b10, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(); ch1_valid = 1'b0;
            #1;
            chk("stall.gap.valid",   {7'd0, out_valid},  8'h00);
            chk("stall.gap.grant",   {6'd0, grant},      8'h02);
            chk("stall.gap.busy",    {7'd0, busy},       8'h01);
            chk("stall.gap.accept0", {7'd0, ch0_accept}, 8'h00);
        end
        tick(); ch1_valid = 1'b1; ch1_data = 8'h42;
        #1 chk_out("stall.d2",  1'b1, 8'h42, 2'b10, 1'b0, 1'b1, 1'b1);
        tick(); ch1_data = 8'h43;
        #1 chk_out("stall.d3",  1'b1, 8'h43, 2'b10, 1'b0, 1'b1, 1'b1);
        tick(); ch1_valid = 1'b0;
        #1 chk_out("stall.end1", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(); chk_out("stall.hdr0", 1'b1, 8'hA0, 2'b01, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("stall.len0", 1'b1, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("stall.dat0", 1'b1, 8'h50, 2'b01, 1'b1, 1'b0, 1'b1);
        tick(); ch0_valid = 1'b0;
        #1 chk_out("stall.end0", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Max length: 256 payload bytes
        ch0_valid = 1'b1; ch0_len = 8'hFF; ch0_data = 8'h00;
        #1 chk_out("max.idle", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(); chk_out("max.hdr", 1'b1, 8'hA0, 2'b01, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("max.len", 1'b1, 8'hFF, 2'b01, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            tick(); ch0_data = 8'(i);
            #1 chk_out("max.dat", 1'b1, 8'(i), 2'b01, 1'b1, 1'b0, 1'b1);
        end
        tick(); ch0_valid = 1'b0;
        #1 chk_out("max.end", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Reset mid-DATA after 2 of 5 payload bytes
        ch1_valid = 1'b1; ch1_len = 8'h04; ch1_data = 8'h60;
        #1 chk_out("mrst.idle", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(); chk_out("mrst.hdr", 1'b1, 8'hA1, 2'b10, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("mrst.len", 1'b1, 8'h04, 2'b10, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("mrst.d0",  1'b1, 8'h60, 2'b10, 1'b0, 1'b1, 1'b1);
        tick(); ch1_data = 8'h61;
        #1 chk_out("mrst.d1",  1'b1, 8'h61, 2'b10, 1'b0, 1'b1, 1'b1);
        tick(); ch1_data = 8'h62;
        #1 chk_out("mrst.d2",  1'b1, 8'h62, 2'b10, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        #1 chk_out("mrst.async", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        ch0_valid = 1'b1; ch0_len = 8'h01; ch0_data = 8'h70;
        #1 chk_out("mrst.idle2", 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(); chk_out("mrst.hdr0", 1'b1, 8'hA0, 2'b01, 1'b0, 1'b0, 1'b1);
        tick(); chk_out("mrst.len0", 1'b1, 8'h01, 2'b01, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
